// File: rtl/sa_cache_ctrl.sv
// sa_cache_ctrl: hit/miss and replacement controller for a 4-way set-associative data cache.
//
// Picks the victim from the LRU priority queue and updates that queue on every hit and
// on every line install. Sequences the dirty-victim writeback and the line fill as
// word-serial bursts, and keeps the hit/miss performance counters.
//
// Ports:
//   CLK, RST_N           clock; synchronous active-low reset
//   cpu_req/cpu_we       CPU access request (held until cpu_ready) and store flag
//   cpu_ready            access completes this cycle
//   hit_vec, dirty_vec   per-way tag-match/valid and dirty bits for the current index
//   lru                  least-recently-used way from the LRU queue
//   lru_we, lru_in       LRU queue write port (mark way most-recently-used)
//   way_sel, word_sel    data/tag array way and burst word offset
//   data_we, set_dirty   data-array write, dirty-bit set
//   tag_we               install tag (valid=1, dirty=cpu_we) into way_sel
//   mem_rd, mem_wr       fill / writeback burst active; mem_ack = one word moved
//   hit_cnt, miss_cnt    wrapping performance counters
module sa_cache_ctrl #(
    parameter int unsigned LINE_WORDS = 8,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic                          cpu_req,
    input  logic                          cpu_we,
    output logic                          cpu_ready,
    input  logic [3:0]                    hit_vec,
    input  logic [3:0]                    dirty_vec,
    input  logic [1:0]                    lru,
    output logic                          lru_we,
    output logic [1:0]                    lru_in,
    output logic [1:0]                    way_sel,
    output logic [$clog2(LINE_WORDS)-1:0] word_sel,
    output logic                          data_we,
    output logic                          set_dirty,
    output logic                          tag_we,
    output logic                          mem_rd,
    output logic                          mem_wr,
    input  logic                          mem_ack,
    output logic [CNT_W-1:0]              hit_cnt,
    output logic [CNT_W-1:0]              miss_cnt
);

    localparam int unsigned WW = $clog2(LINE_WORDS);
    localparam logic [WW-1:0] LastWord = WW'(LINE_WORDS - 1);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WRITEBACK = 2'd1;
    localparam logic [1:0] ST_FILL      = 2'd2;
    localparam logic [1:0] ST_INSTALL   = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [WW-1:0]    cnt_q, cnt_d;
    logic [1:0]       victim_q, victim_d;
    logic             replay_q, replay_d;
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
    logic [1:0]       hit_way;

    // Multiple matches are illegal; resolve deterministically to the lowest way.
    always_comb begin
        hit_way = 2'd0;
        if (hit_vec[0])      hit_way = 2'd0;
        else if (hit_vec[1]) hit_way = 2'd1;
        else if (hit_vec[2]) hit_way = 2'd2;
        else if (hit_vec[3]) hit_way = 2'd3;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        victim_d   = victim_q;
        replay_d   = replay_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        cpu_ready  = 1'b0;
        lru_we     = 1'b0;
        lru_in     = 2'd0;
        way_sel    = 2'd0;
        word_sel   = '0;
        data_we    = 1'b0;
        set_dirty  = 1'b0;
        tag_we     = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cpu_req) begin
                    if (|hit_vec) begin
                        cpu_ready = 1'b1;
                        way_sel   = hit_way;
                        lru_we    = 1'b1;
                        lru_in    = hit_way;
                        data_we   = cpu_we;
                        set_dirty = cpu_we;
                        // The post-install replay was already counted as a miss.
                        if (!replay_q) hit_cnt_d = hit_cnt_q + CNT_W'(1);
                        replay_d = 1'b0;
                    end else begin
                        victim_d   = lru;
                        miss_cnt_d = miss_cnt_q + CNT_W'(1);
                        replay_d   = 1'b0;
                        state_d    = dirty_vec[lru] ? ST_WRITEBACK : ST_FILL;
                    end
                end else begin
                    // Request abandoned during the miss: no replay will follow, so the
                    // next hit is a real access and must be counted.
                    replay_d = 1'b0;
                end
            end
            ST_WRITEBACK: begin
                mem_wr   = 1'b1;
                way_sel  = victim_q;
                word_sel = cnt_q;
                if (mem_ack) begin
                    if (cnt_q == LastWord) begin
                        cnt_d   = '0;
                        state_d = ST_FILL;
                    end else begin
                        cnt_d = cnt_q + WW'(1);
                    end
                end
            end
            ST_FILL: begin
                mem_rd   = 1'b1;
                way_sel  = victim_q;
                word_sel = cnt_q;
                data_we  = mem_ack;
                if (mem_ack) begin
                    if (cnt_q == LastWord) begin
                        cnt_d   = '0;
                        state_d = ST_INSTALL;
                    end else begin
                        cnt_d = cnt_q + WW'(1);
                    end
                end
            end
            ST_INSTALL: begin
                tag_we   = 1'b1;
                way_sel  = victim_q;
                lru_we   = 1'b1;
                lru_in   = victim_q;
                replay_d = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            victim_q   <= 2'd0;
            replay_q   <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            victim_q   <= victim_d;
            replay_q   <= replay_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_sa_cache_ctrl.sv
// tb_sa_cache_ctrl: self-checking bench for sa_cache_ctrl.
// Drives whole CPU accesses (hit, clean miss, dirty miss, abandoned miss) and predicts
// every cycle's outputs from access-level rules; counters are modelled as plain totals.
module tb_sa_cache_ctrl;

    localparam int unsigned LW   = 8;
    localparam int unsigned CW   = 4;
    localparam int unsigned WW   = 3;
    localparam int          MASK = (1 << CW) - 1;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [3:0]    hit_vec = 4'd0;
    logic [3:0]    dirty_vec = 4'd0;
    logic [1:0]    lru = 2'd0;
    logic          mem_ack = 1'b0;
    logic          cpu_ready, lru_we, data_we, set_dirty, tag_we, mem_rd, mem_wr;
    logic [1:0]    lru_in, way_sel;
    logic [WW-1:0] word_sel;
    logic [CW-1:0] hit_cnt, miss_cnt;
    logic [31:0]   obs;

    int vectors = 0;
    int errors  = 0;
    int m_hit   = 0;
    int m_miss  = 0;

    sa_cache_ctrl #(.LINE_WORDS(LW), .CNT_W(CW)) dut (
        .CLK(CLK), .RST_N(RST_N), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_ready(cpu_ready), .hit_vec(hit_vec), .dirty_vec(dirty_vec), .lru(lru),
        .lru_we(lru_we), .lru_in(lru_in), .way_sel(way_sel), .word_sel(word_sel),
        .data_we(data_we), .set_dirty(set_dirty), .tag_we(tag_we), .mem_rd(mem_rd),
        .mem_wr(mem_wr), .mem_ack(mem_ack), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 CLK = ~CLK;

    assign obs = 32'({cpu_ready, lru_we, lru_in, way_sel, word_sel, data_we, set_dirty,
                      tag_we, mem_rd, mem_wr});

    function automatic logic [31:0] pk(input logic rdy, input logic lwe, input logic [1:0] lin,
                                       input logic [1:0] ws, input logic [WW-1:0] wd,
                                       input logic dwe, input logic sd, input logic twe,
                                       input logic rd, input logic wr);
        return 32'({rdy, lwe, lin, ws, wd, dwe, sd, twe, rd, wr});
    endfunction

    function automatic logic [1:0] lowest(input logic [3:0] v);
        for (int i = 3; i >= 0; i--) if (v[i]) lowest = 2'(i);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_cnts(input string tag);
        check({tag, "_hit_cnt"}, 32'(hit_cnt), 32'(m_hit & MASK));
        check({tag, "_miss_cnt"}, 32'(miss_cnt), 32'(m_miss & MASK));
    endtask

    // One burst of LW words; mode 0 = ack every cycle, 1 = every other cycle, 2 = random.
    task automatic burst(input bit rd, input logic [1:0] v, input int mode, input bit drop);
        bit    tog;
        int    guard;
        string tg;
        tog = 1'b0;
        tg  = rd ? "fill" : "writeback";
        for (int k = 0; k < LW; k++) begin
            guard = 0;
            do begin
                case (mode)
                    0:       mem_ack = 1'b1;
                    1:       begin mem_ack = tog; tog = !tog; end
                    default: mem_ack = 1'($urandom_range(0, 1));
                endcase
                if (drop && rd && k == 3) cpu_req = 1'b0;
                #1 check(tg, obs, pk(0, 0, 0, v, k[WW-1:0], rd & mem_ack, 0, 0, rd, !rd));
                guard++;
                @(negedge CLK);
            end while (!mem_ack && guard < 200);
            if (!mem_ack) begin
                vectors++;
                errors++;
                $error("FAIL burst_timeout: observed no ack required ack");
                $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
                $finish;
            end
        end
    endtask

    task automatic access(input logic we, input logic [3:0] hv, input logic [3:0] dv,
                          input logic [1:0] lv, input int mode, input bit drop);
        logic [1:0] w;
        cpu_req = 1'b1; cpu_we = we; hit_vec = hv; dirty_vec = dv; lru = lv;
        mem_ack = 1'($urandom_range(0, 1));  // must be ignored in idle
        #1;
        if (hv != 4'd0) begin
            w = lowest(hv);
            check("hit", obs, pk(1, 1, w, w, 0, we, we, 0, 0, 0));
            m_hit++;
            @(negedge CLK);
            check_cnts("hit");
        end else begin
            check("miss_detect", obs, pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            m_miss++;
            @(negedge CLK);
            check_cnts("miss");
            // Victim must already be latched; scramble the live inputs.
            lru = 2'($urandom); dirty_vec = 4'($urandom);
            if (dv[lv]) burst(1'b0, lv, mode, 1'b0);
            burst(1'b1, lv, mode, drop);
            mem_ack = 1'($urandom_range(0, 1));
            #1 check("install", obs, pk(0, 1, lv, lv, 0, 0, 0, 1, 0, 0));
            @(negedge CLK);
            if (drop) begin
                mem_ack = 1'b1;
                #1 check("idle_after_drop", obs, 32'd0);
                @(negedge CLK);
                check_cnts("drop");
            end else begin
                hit_vec = 4'b0001 << lv; lru = 2'($urandom);
                #1 check("replay", obs, pk(1, 1, lv, lv, 0, we, we, 0, 0, 0));
                @(negedge CLK);
                check_cnts("replay");  // replay completes the miss, not a new hit
            end
        end
    endtask

    initial begin
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        mem_ack = 1'b1;
        #1 check("reset_idle", obs, 32'd0);
        check_cnts("reset");
        @(negedge CLK);

        access(1'b1, 4'b0100, 4'b0000, 2'd0, 0, 1'b0);  // store hit way 2
        access(1'b0, 4'b0000, 4'b0000, 2'd3, 0, 1'b0);  // clean miss
        access(1'b0, 4'b0000, 4'b0010, 2'd1, 1, 1'b0);  // dirty miss, slow acks

        // Reset during fill word 4
        cpu_req = 1'b1; cpu_we = 1'b0; hit_vec = 4'd0; dirty_vec = 4'd0; lru = 2'd2;
        mem_ack = 1'b1;
        #1 check("rst_miss", obs, 32'd0);
        @(negedge CLK);
        for (int k = 0; k < 5; k++) begin
            #1 check("rst_fill", obs, pk(0, 0, 0, 2'd2, k[WW-1:0], 1, 0, 0, 1, 0));
            if (k == 4) RST_N = 1'b0;
            @(negedge CLK);
        end
        RST_N = 1'b1; cpu_req = 1'b0;
        m_hit = 0; m_miss = 0;
        for (int k = 0; k < 3; k++) begin
            #1 check("post_rst", obs, 32'd0);
            check_cnts("post_rst");
            @(negedge CLK);
        end

        access(1'b0, 4'b0000, 4'b0000, 2'd2, 2, 1'b1);  // abandoned miss
        access(1'b0, 4'b0001, 4'b0000, 2'd0, 0, 1'b0);  // real hit is counted
        access(1'b1, 4'b1010, 4'b0000, 2'd0, 0, 1'b0);  // lowest index wins
        for (int i = 0; i < 16; i++) access(1'b0, 4'b1000, 4'b0000, 2'd0, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            access(1'($urandom_range(0, 1)),
                   ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0,
                   4'($urandom), 2'($urandom), $urandom_range(0, 2),
                   $urandom_range(0, 7) == 0);
        end

        cpu_req = 1'b0;
        @(negedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
